// File: rtl/execute.sv
// Execute (EX) stage of the 64-bit RISC-V sequential processor.
// Selects the ALU operand B, performs the ALU operation, derives Zero and
// the beq decision, and registers everything at the EX/MEM boundary.
module execute #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] ReadData1,
  input  logic [XLEN-1:0] ReadData2,
  input  logic [XLEN-1:0] ImmExt,
  input  logic [4:0]      Rd,
  input  logic [3:0]      ALUOp,
  input  logic            ALUSrc,
  input  logic            Branch,
  input  logic            MemRead,
  input  logic            MemtoReg,
  input  logic            MemWrite,
  input  logic            RegWrite,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero,
  output logic            BranchTaken,
  output logic [XLEN-1:0] WriteData,
  output logic [4:0]      RdOut,
  output logic            MemReadOut,
  output logic            MemtoRegOut,
  output logic            MemWriteOut,
  output logic            RegWriteOut
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD_MEM = 4'b0000,
    OP_OR      = 4'b0001,
    OP_ADD     = 4'b0010,
    OP_XOR     = 4'b0011,
    OP_SLL     = 4'b0100,
    OP_SRL     = 4'b0101,
    OP_SUB     = 4'b0110,
    OP_AND     = 4'b0111,
    OP_SRA     = 4'b1000,
    OP_SLT     = 4'b1001,
    OP_SLTU    = 4'b1010
  } alu_op_e;

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] result;
  logic            result_zero;

  assign op_a        = ReadData1;
  assign op_b        = ALUSrc ? ImmExt : ReadData2;
  assign shamt       = op_b[SHW-1:0];
  assign result_zero = (result == '0);

  // ALU: combinational result for the selected operation.
  always_comb begin
    // NOTE: default assigned first so no path leaves result unassigned (no latch).
    result = '0;
    case (ALUOp)
      OP_ADD_MEM,
      OP_ADD:  result = op_a + op_b;
      OP_OR:   result = op_a | op_b;
      OP_XOR:  result = op_a ^ op_b;
      OP_SLL:  result = op_a << shamt;
      OP_SRL:  result = op_a >> shamt;
      OP_SUB:  result = op_a - op_b;
      OP_AND:  result = op_a & op_b;
      OP_SRA:  result = $unsigned($signed(op_a) >>> shamt);
      OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default: result = '0;
    endcase
  end

  // EX/MEM register: captures ALU outputs and forwarded controls every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUResult   <= '0;
      Zero        <= 1'b0;
      BranchTaken <= 1'b0;
      WriteData   <= '0;
      RdOut       <= '0;
      MemReadOut  <= 1'b0;
      MemtoRegOut <= 1'b0;
      MemWriteOut <= 1'b0;
      RegWriteOut <= 1'b0;
    end else begin
      // NOTE: non-blocking so every output samples pre-edge values together.
      ALUResult   <= result;
      Zero        <= result_zero;
      BranchTaken <= Branch & result_zero;
      WriteData   <= ReadData2;
      RdOut       <= Rd;
      MemReadOut  <= MemRead;
      MemtoRegOut <= MemtoReg;
      MemWriteOut <= MemWrite;
      RegWriteOut <= RegWrite;
    end
  end

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the execute stage: directed steps push expected
// results into a scoreboard queue; each clock the head is popped and compared.
module tb_execute;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst_n;
  logic [XLEN-1:0] ReadData1, ReadData2, ImmExt;
  logic [4:0]      Rd;
  logic [3:0]      ALUOp;
  logic            ALUSrc, Branch, MemRead, MemtoReg, MemWrite, RegWrite;
  logic [XLEN-1:0] ALUResult, WriteData;
  logic            Zero, BranchTaken;
  logic [4:0]      RdOut;
  logic            MemReadOut, MemtoRegOut, MemWriteOut, RegWriteOut;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic            br;
    logic [XLEN-1:0] wdata;
    logic [4:0]      rd;
    logic            mr;
    logic            m2r;
    logic            mw;
    logic            rw;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  execute #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ReadData1   (ReadData1),
    .ReadData2   (ReadData2),
    .ImmExt      (ImmExt),
    .Rd          (Rd),
    .ALUOp       (ALUOp),
    .ALUSrc      (ALUSrc),
    .Branch      (Branch),
    .MemRead     (MemRead),
    .MemtoReg    (MemtoReg),
    .MemWrite    (MemWrite),
    .RegWrite    (RegWrite),
    .ALUResult   (ALUResult),
    .Zero        (Zero),
    .BranchTaken (BranchTaken),
    .WriteData   (WriteData),
    .RdOut       (RdOut),
    .MemReadOut  (MemReadOut),
    .MemtoRegOut (MemtoRegOut),
    .MemWriteOut (MemWriteOut),
    .RegWriteOut (RegWriteOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the run must never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ALUResult"},   ALUResult,   '0);
    check({tag, ".Zero"},        Zero,        '0);
    check({tag, ".BranchTaken"}, BranchTaken, '0);
    check({tag, ".WriteData"},   WriteData,   '0);
    check({tag, ".RdOut"},       RdOut,       '0);
    check({tag, ".MemReadOut"},  MemReadOut,  '0);
    check({tag, ".MemtoRegOut"}, MemtoRegOut, '0);
    check({tag, ".MemWriteOut"}, MemWriteOut, '0);
    check({tag, ".RegWriteOut"}, RegWriteOut, '0);
  endtask

  // Drive one instruction and push what the EX/MEM register must hold next.
  task automatic issue(input logic [XLEN-1:0] a, input logic [XLEN-1:0] rd2,
                       input logic [XLEN-1:0] imm, input logic [4:0] rd,
                       input logic [3:0] op, input logic src, input logic br,
                       input logic mr, input logic m2r, input logic mw,
                       input logic rw, input logic [XLEN-1:0] exp_result,
                       input logic exp_zero, input logic exp_br);
    exp_t e;
    ReadData1 = a;  ReadData2 = rd2; ImmExt = imm; Rd = rd;
    ALUOp = op; ALUSrc = src; Branch = br;
    MemRead = mr; MemtoReg = m2r; MemWrite = mw; RegWrite = rw;
    e.result = exp_result; e.zero = exp_zero; e.br = exp_br;
    e.wdata = rd2; e.rd = rd; e.mr = mr; e.m2r = m2r; e.mw = mw; e.rw = rw;
    sb_q.push_back(e);
  endtask

  // Advance one edge, sample 1 time unit later, compare against queue head.
  task automatic step_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: observed empty scoreboard required an entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".ALUResult"},   ALUResult,   e.result);
      check({tag, ".Zero"},        Zero,        e.zero);
      check({tag, ".BranchTaken"}, BranchTaken, e.br);
      check({tag, ".WriteData"},   WriteData,   e.wdata);
      check({tag, ".RdOut"},       RdOut,       e.rd);
      check({tag, ".MemReadOut"},  MemReadOut,  e.mr);
      check({tag, ".MemtoRegOut"}, MemtoRegOut, e.m2r);
      check({tag, ".MemWriteOut"}, MemWriteOut, e.mw);
      check({tag, ".RegWriteOut"}, RegWriteOut, e.rw);
    end
  endtask

  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] MSB  = 64'h8000_0000_0000_0000;

  initial begin
    // Reset held low with nonzero inputs: outputs stay zero across edges.
    rst_n = 1'b0;
    ReadData1 = 64'h1234; ReadData2 = 64'h5678; ImmExt = 64'h9A; Rd = 5'd7;
    ALUOp = 4'b0010; ALUSrc = 1'b0; Branch = 1'b1;
    MemRead = 1'b1; MemtoReg = 1'b1; MemWrite = 1'b1; RegWrite = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_hold");

    // First capture after release: ADD 5+3.
    issue(64'd5, 64'd3, 64'd0, 5'd1, 4'b0010, 1'b0, 1'b0,
          1'b0, 1'b0, 1'b0, 1'b1, 64'd8, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    step_check("add_after_reset");

    // R-type ops, back to back.
    issue(64'hA, 64'h4, 64'h0, 5'd2, 4'b0110, 1'b0, 1'b0,
          1'b0, 1'b0, 1'b0, 1'b1, 64'h6, 1'b0, 1'b0);
    step_check("sub");
    issue(64'hFF, 64'hF, 64'h0, 5'd3, 4'b0111, 1'b0, 1'b0,
          1'b0, 1'b0, 1'b0, 1'b1, 64'hF, 1'b0, 1'b0);
    step_check("and");
    issue(64'h50, 64'hF, 64'h0, 5'd4, 4'b0001, 1'b0, 1'b0,
          1'b0, 1'b0, 1'b0, 1'b1, 64'h5F, 1'b0, 1'b0);
    step_check("or");
    issue(64'hF0, 64'hFF, 64'h0, 5'd5, 4'b0011, 1'b0, 1'b0,
          1'b0, 1'b0, 1'b0, 1'b1, 64'h0F, 1'b0, 1'b0);
    step_check("xor");

    // ld / sd address calculation with immediate operand.
    issue(64'h100, 64'h55, 64'h8, 5'd6, 4'b0000, 1'b1, 1'b0,
          1'b1, 1'b1, 1'b0, 1'b1, 64'h108, 1'b0, 1'b0);
    step_check("ld");
    issue(64'h100, 64'hDEAD_BEEF_DEAD_BEEF, 64'h10, 5'd0, 4'b0000, 1'b1, 1'b0,
          1'b0, 1'b0, 1'b1, 1'b0, 64'h110, 1'b0, 1'b0);
    step_check("sd");

    // beq taken / not taken.
    issue(64'h25, 64'h25, 64'h0, 5'd0, 4'b0110, 1'b0, 1'b1,
          1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
    step_check("beq_taken");
    issue(64'h25, 64'h26, 64'h0, 5'd0, 4'b0110, 1'b0, 1'b1,
          1'b0, 1'b0, 1'b0, 1'b0, ONES, 1'b0, 1'b0);
    step_check("beq_not_taken");

    // Zero on a non-branch op.
    issue(64'h0, 64'h0, 64'h0, 5'd9, 4'b0010, 1'b0, 1'b0,
          1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0);
    step_check("zero_no_branch");

    // Shifts.
    issue(64'h1, 64'd63, 64'h0, 5'd10, 4'b0100, 1'b0, 1'b0,
          1'b0, 1'b0, 1'b0, 1'b1, MSB, 1'b0, 1'b0);
    step_check("sll63");

    // Async reset pulse between edges: outputs clear without a clock edge.
    issue(MSB, 64'h0, 64'd63, 5'd11, 4'b1000, 1'b1, 1'b0,
          1'b0, 1'b0, 1'b0, 1'b1, ONES, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset_low");
    #1 rst_n = 1'b1;
    #1 check_all_zero("async_reset_released");
    step_check("sra63");

    issue(MSB, 64'd63, 64'h0, 5'd12, 4'b0101, 1'b0, 1'b0,
          1'b0, 1'b0, 1'b0, 1'b1, 64'h1, 1'b0, 1'b0);
    step_check("srl63");

    // Signed vs unsigned compare.
    issue(ONES, 64'h1, 64'h0, 5'd13, 4'b1001, 1'b0, 1'b0,
          1'b0, 1'b0, 1'b0, 1'b1, 64'h1, 1'b0, 1'b0);
    step_check("slt");
    issue(ONES, 64'h1, 64'h0, 5'd14, 4'b1010, 1'b0, 1'b0,
          1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0);
    step_check("sltu");

    // Undefined codes yield 0; Zero then drives BranchTaken when Branch=1.
    issue(64'h5, 64'h3, 64'h0, 5'd15, 4'b1111, 1'b0, 1'b1,
          1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
    step_check("undef_1111");
    issue(64'h5, 64'h3, 64'h0, 5'd16, 4'b1011, 1'b0, 1'b0,
          1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0);
    step_check("undef_1011");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
